operation_encoder: RTL and testbench

- Converts the decoded PS/2 keyboard byte stream into the per-cycle `operation_code` and `boost` consumed by the physics engine stage directly downstream.
- Parses make, break and extended (E0) sequences and tracks which driving keys are held.
- Resolves conflicting keys with a last-pressed-wins rule.
- Gates its outputs with the game state from the state encoder.

---
 rtl/op_pkg.sv | 77 +++++++
 rtl/operation_encoder_if.sv | 27 ++
 rtl/operation_encoder_ps2_seq_parser.sv | 83 ++++++++
 rtl/operation_encoder.sv | 107 ++++++++++
 tb/tb_operation_encoder.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/op_pkg.sv
// ---------------------------------------------------------------------------
// op_pkg
// Shared definitions for the driving-control path: operation encodings
// consumed by the physics engine, game-state encodings from the state
// encoder, PS/2 prefix bytes and the driving-key scan codes.
// Also holds the parser state type, the held-key record and the
// left/right and forward/back conflict-resolution function.
// ---------------------------------------------------------------------------
package op_pkg;

    typedef enum logic [2:0] {
        OP_NIL      = 3'd0,
        OP_FORWARD  = 3'd1,
        OP_BACKWARD = 3'd2,
        OP_LEFT     = 3'd3,
        OP_RIGHT    = 3'd4
    } op_e;

    // Game state in which the driving outputs are live.
    localparam logic [2:0] STATE_RACE = 3'd2;

    // PS/2 set-2 prefix bytes.
    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    // Plain (WASD + shift) scan codes.
    localparam logic [7:0] CODE_FWD   = 8'h1D;
    localparam logic [7:0] CODE_BWD   = 8'h1B;
    localparam logic [7:0] CODE_LEFT  = 8'h1C;
    localparam logic [7:0] CODE_RIGHT = 8'h23;
    localparam logic [7:0] CODE_BOOST = 8'h12;

    // Extended (E0-prefixed) arrow scan codes.
    localparam logic [7:0] EXT_CODE_UP    = 8'h75;
    localparam logic [7:0] EXT_CODE_DOWN  = 8'h72;
    localparam logic [7:0] EXT_CODE_LEFT  = 8'h6B;
    localparam logic [7:0] EXT_CODE_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_EXT,
        PS_BRK,
        PS_EXT_BRK
    } parse_state_e;

    // One bit per logical key; a WASD key and its arrow alias share a bit.
    typedef struct packed {
        logic fwd;
        logic bwd;
        logic left;
        logic right;
        logic boost;
    } held_t;

    // Horizontal keys take priority over vertical ones. Within an axis,
    // a single held key wins outright; when both are held the most
    // recently pressed one (last_h / last_v) wins.
    function automatic op_e resolve(held_t held, op_e last_h, op_e last_v);
        op_e result;
        result = OP_NIL;
        if (held.left && held.right) begin
            result = last_h;
        end else if (held.left) begin
            result = OP_LEFT;
        end else if (held.right) begin
            result = OP_RIGHT;
        end else if (held.fwd && held.bwd) begin
            result = last_v;
        end else if (held.fwd) begin
            result = OP_FORWARD;
        end else if (held.bwd) begin
            result = OP_BACKWARD;
        end
        return result;
    endfunction

endpackage

// File: rtl/operation_encoder_if.sv
// ---------------------------------------------------------------------------
// operation_encoder_if
// Bundles the keyboard byte stream, the game state and the driving outputs.
//   key_valid      : one-cycle strobe, key_code valid this cycle
//   key_code[7:0]  : byte from the PS/2 receiver
//   state[2:0]     : current game state
//   operation_code : 0 NIL, 1 FORWARD, 2 BACKWARD, 3 LEFT, 4 RIGHT
//   boost          : boost requested
// master = producer of bytes/state (and consumer of outputs); slave = encoder.
// ---------------------------------------------------------------------------
interface operation_encoder_if;
    logic       key_valid;
    logic [7:0] key_code;
    logic [2:0] state;
    logic [2:0] operation_code;
    logic       boost;

    modport master (
        output key_valid, key_code, state,
        input  operation_code, boost
    );

    modport slave (
        input  key_valid, key_code, state,
        output operation_code, boost
    );
endinterface

// File: rtl/operation_encoder_ps2_seq_parser.sv
// ---------------------------------------------------------------------------
// ps2_seq_parser
// Prefix FSM for PS/2 set-2 make/break/extended sequences. Emits a
// single-cycle event in the same cycle as the final byte of a sequence.
//   clk, rst_n          : clock, async active-low reset
//   key_valid, key_code : incoming byte strobe and data
//   ev_valid            : a complete sequence ended this cycle
//   ev_make             : 1 = make, 0 = break
//   ev_ext              : sequence carried the E0 prefix
//   ev_code             : final byte of the sequence
// ---------------------------------------------------------------------------
module ps2_seq_parser
    import op_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       ev_valid,
    output logic       ev_make,
    output logic       ev_ext,
    output logic [7:0] ev_code
);

    parse_state_e state_q, state_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        ev_valid = 1'b0;
        ev_make  = 1'b0;
        ev_ext   = 1'b0;
        ev_code  = key_code;

        if (key_valid) begin
            unique case (state_q)
                PS_IDLE: begin
                    if (key_code == PREFIX_EXT) begin
                        state_d = PS_EXT;
                    end else if (key_code == PREFIX_BRK) begin
                        state_d = PS_BRK;
                    end else begin
                        ev_valid = 1'b1;
                        ev_make  = 1'b1;
                    end
                end
                PS_EXT: begin
                    // A repeated E0 keeps us waiting for the extended byte.
                    if (key_code == PREFIX_BRK) begin
                        state_d = PS_EXT_BRK;
                    end else if (key_code != PREFIX_EXT) begin
                        ev_valid = 1'b1;
                        ev_make  = 1'b1;
                        ev_ext   = 1'b1;
                        state_d  = PS_IDLE;
                    end
                end
                PS_BRK: begin
                    ev_valid = 1'b1;
                    state_d  = PS_IDLE;
                end
                PS_EXT_BRK: begin
                    ev_valid = 1'b1;
                    ev_ext   = 1'b1;
                    state_d  = PS_IDLE;
                end
                default: state_d = PS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) begin
            state_q <= PS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/operation_encoder.sv
// ---------------------------------------------------------------------------
// operation_encoder
// Turns the PS/2 byte stream into the registered per-cycle operation_code
// and boost for the physics engine. Tracks held driving keys, resolves
// conflicts last-pressed-wins, and forces outputs to zero outside the
// race state.
//   clk, rst_n : clock, async active-low reset
//   bus        : operation_encoder_if.slave (key_valid, key_code, state in;
//                operation_code, boost out)
// ---------------------------------------------------------------------------
module operation_encoder
    import op_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    operation_encoder_if.slave   bus
);

    logic       ev_valid;
    logic       ev_make;
    logic       ev_ext;
    logic [7:0] ev_code;

    ps2_seq_parser u_parser (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (bus.key_valid),
        .key_code  (bus.key_code),
        .ev_valid  (ev_valid),
        .ev_make   (ev_make),
        .ev_ext    (ev_ext),
        .ev_code   (ev_code)
    );

    held_t held_q, held_d;
    op_e   last_h_q, last_h_d;
    op_e   last_v_q, last_v_d;
    op_e   op_q, op_d;
    logic  boost_q, boost_d;

    logic hit_fwd, hit_bwd, hit_left, hit_right, hit_boost;

    always_comb begin
        hit_fwd   = (!ev_ext && ev_code == CODE_FWD)   || (ev_ext && ev_code == EXT_CODE_UP);
        hit_bwd   = (!ev_ext && ev_code == CODE_BWD)   || (ev_ext && ev_code == EXT_CODE_DOWN);
        hit_left  = (!ev_ext && ev_code == CODE_LEFT)  || (ev_ext && ev_code == EXT_CODE_LEFT);
        hit_right = (!ev_ext && ev_code == CODE_RIGHT) || (ev_ext && ev_code == EXT_CODE_RIGHT);
        // E0 12 is the keyboard's fake shift and must not count as boost.
        hit_boost = !ev_ext && ev_code == CODE_BOOST;

        held_d   = held_q;
        last_h_d = last_h_q;
        last_v_d = last_v_q;

        if (ev_valid) begin
            if (hit_fwd) begin
                held_d.fwd = ev_make;
                if (ev_make) last_v_d = OP_FORWARD;
            end
            if (hit_bwd) begin
                held_d.bwd = ev_make;
                if (ev_make) last_v_d = OP_BACKWARD;
            end
            if (hit_left) begin
                held_d.left = ev_make;
                if (ev_make) last_h_d = OP_LEFT;
            end
            if (hit_right) begin
                held_d.right = ev_make;
                if (ev_make) last_h_d = OP_RIGHT;
            end
            if (hit_boost) begin
                held_d.boost = ev_make;
            end
        end

        // Resolve from the next-state values so a key event shows on the
        // outputs one cycle after its final byte.
        op_d    = resolve(held_d, last_h_d, last_v_d);
        boost_d = held_d.boost && (op_d != OP_NIL);

        if (bus.state != STATE_RACE) begin
            op_d    = OP_NIL;
            boost_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q   <= '0;
            last_h_q <= OP_LEFT;
            last_v_q <= OP_FORWARD;
            op_q     <= OP_NIL;
            boost_q  <= 1'b0;
        end else begin
            held_q   <= held_d;
            last_h_q <= last_h_d;
            last_v_q <= last_v_d;
            op_q     <= op_d;
            boost_q  <= boost_d;
        end
    end

    assign bus.operation_code = op_q;
    assign bus.boost          = boost_q;

endmodule

// File: tb/tb_operation_encoder.sv
// ---------------------------------------------------------------------------
// tb_operation_encoder
// Directed byte sequences with hand-computed expected operation_code/boost.
// Inputs change on the falling edge; outputs are sampled on a later falling
// edge, i.e. half a cycle after the rising edge that updates them.
// ---------------------------------------------------------------------------
module tb_operation_encoder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    operation_encoder_if bus ();

    operation_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] exp_op, input logic exp_boost);
        check({tag, ".op"},    {5'd0, bus.operation_code}, {5'd0, exp_op});
        check({tag, ".boost"}, {7'd0, bus.boost},          {7'd0, exp_boost});
    endtask

    // Present one byte for exactly one cycle; back-to-back calls give
    // consecutive key_valid cycles.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = b;
    endtask

    // Drop key_valid; by this falling edge the last byte has been captured.
    task automatic idle();
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        bus.state     = 3'd2;

        repeat (2) @(negedge clk);
        check_out("reset", 3'd0, 1'b0);
        rst_n = 1'b1;
        idle();

        // W press / release
        send(8'h1D);
        #1 check_out("w_before_edge", 3'd0, 1'b0);
        idle();
        check_out("w_make", 3'd1, 1'b0);
        send(8'hF0); idle();
        check_out("w_after_f0", 3'd1, 1'b0);
        send(8'h1D); idle();
        check_out("w_break", 3'd0, 1'b0);

        // A, D, release D: only left remains held
        send(8'h1C); idle();
        check_out("a_make", 3'd3, 1'b0);
        send(8'h23); idle();
        check_out("d_make", 3'd4, 1'b0);
        send(8'hF0); send(8'h23); idle();
        check_out("d_break", 3'd3, 1'b0);
        // Both held again, then a typematic repeat of A re-takes priority
        send(8'h23); idle();
        check_out("d_remake", 3'd4, 1'b0);
        send(8'h1C); idle();
        check_out("a_repeat", 3'd3, 1'b0);
        send(8'hF0); send(8'h1C); idle();
        check_out("a_break", 3'd4, 1'b0);
        send(8'hF0); send(8'h23); idle();
        check_out("all_h_break", 3'd0, 1'b0);

        // Shift with up arrow, fake shift, shift release
        send(8'h12); idle();
        check_out("shift_alone", 3'd0, 1'b0);
        send(8'hE0); send(8'h75); idle();
        check_out("up_boost", 3'd1, 1'b1);
        send(8'hE0); send(8'h12); idle();
        check_out("fake_shift", 3'd1, 1'b1);
        send(8'hF0); send(8'h12); idle();
        check_out("shift_break", 3'd1, 1'b0);
        // Releasing W clears the bit the up arrow set
        send(8'hF0); send(8'h1D); idle();
        check_out("alias_break", 3'd0, 1'b0);

        // Left arrow beats W; release left arrow leaves W
        send(8'hE0); send(8'h6B); idle();
        check_out("left_arrow", 3'd3, 1'b0);
        send(8'h1D); idle();
        check_out("h_priority", 3'd3, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h6B); idle();
        check_out("ext_break", 3'd1, 1'b0);
        send(8'hF0); send(8'h1D); idle();
        check_out("w_break2", 3'd0, 1'b0);

        // Gating: S held outside the race state, then race begins
        bus.state = 3'd0;
        send(8'h1B); idle();
        check_out("gated", 3'd0, 1'b0);
        @(negedge clk);
        bus.state = 3'd2;
        #1 check_out("ungate_same_cycle", 3'd0, 1'b0);
        @(negedge clk);
        check_out("ungate", 3'd2, 1'b0);

        // Reset after a lone E0 discards the prefix and the held S
        send(8'hE0);
        @(negedge clk);
        bus.key_valid = 1'b0;
        rst_n         = 1'b0;
        #1 check_out("in_reset0", 3'd0, 1'b0);
        repeat (2) @(negedge clk);
        check_out("in_reset2", 3'd0, 1'b0);
        rst_n = 1'b1;
        send(8'h74); idle();
        check_out("post_reset_74", 3'd0, 1'b0);
        send(8'h1C); send(8'h23); idle();
        check_out("post_reset_ad", 3'd4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
